// File: rtl/pixel_fb_writer.sv
// rtl/pixel_fb_writer.sv - crops camera pixels into a double-buffered frame buffer and drains them over a req/ack write port
// Pipeline: input register -> address stage -> FIFO -> two-state write FSM.
module pixel_fb_writer #(
  parameter int H_RES      = 320,
  parameter int V_RES      = 240,
  parameter int ADDR_W     = 18,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iEn,
  input  logic [35:0]       iData,
  input  logic              iWrAck,
  output logic              oWrReq,
  output logic [ADDR_W-1:0] oWrAddr,
  output logic [15:0]       oWrData,
  output logic              oFrameDone,
  output logic              oDoneBank,
  input  logic              iClrOvf,
  output logic              oOverflow
);
  localparam logic [31:0] H_RES_U = 32'(H_RES);
  localparam logic [31:0] V_RES_U = 32'(V_RES);
  localparam logic [31:0] FRAME_U = 32'(H_RES * V_RES);
  localparam int          PW      = $clog2(FIFO_DEPTH);
  localparam int          EW      = ADDR_W + 17;

  typedef enum logic {S_IDLE, S_REQ} state_t;

  logic              in_range;
  logic              in_valid_q;
  logic [9:0]        in_x_q, in_y_q;
  logic [15:0]       in_rgb_q;
  logic              is_origin, px_last;
  logic              cur_bank_q, cur_bank_d, seen_q, seen_d;
  logic [31:0]       addr_full;
  logic              s1_valid_q;
  logic [EW-1:0]     s1_entry_q;
  logic [EW-1:0]     mem_q [FIFO_DEPTH];
  logic [PW:0]       wr_ptr_q, rd_ptr_q;
  logic              fifo_empty, fifo_full, push, drop, pop;
  logic [EW-1:0]     head;
  logic              ovf_q;
  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic              done_bank_q, done_bank_d;

  assign in_range = iEn && (32'(iData[35:26]) < H_RES_U) && (32'(iData[25:16]) < V_RES_U);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_valid_q <= 1'b0;
      in_x_q     <= '0;
      in_y_q     <= '0;
      in_rgb_q   <= '0;
    end else begin
      in_valid_q <= in_range;
      if (in_range) begin
        in_x_q   <= iData[35:26];
        in_y_q   <= iData[25:16];
        in_rgb_q <= iData[15:0];
      end
    end
  end

  // The (0,0) pixel flips the bank before its own address is formed.
  always_comb begin
    is_origin  = (in_x_q == '0) && (in_y_q == '0);
    cur_bank_d = cur_bank_q;
    seen_d     = seen_q;
    if (in_valid_q && is_origin) begin
      if (seen_q) cur_bank_d = ~cur_bank_q;
      seen_d = 1'b1;
    end
    addr_full = (cur_bank_d ? FRAME_U : 32'd0) + 32'(in_y_q) * H_RES_U + 32'(in_x_q);
    px_last   = (32'(in_x_q) == H_RES_U - 32'd1) && (32'(in_y_q) == V_RES_U - 32'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_entry_q <= '0;
      cur_bank_q <= 1'b0;
      seen_q     <= 1'b0;
    end else begin
      s1_valid_q <= in_valid_q;
      cur_bank_q <= cur_bank_d;
      seen_q     <= seen_d;
      if (in_valid_q) s1_entry_q <= {addr_full[ADDR_W-1:0], in_rgb_q, px_last};
    end
  end

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign push       = s1_valid_q && !fifo_full;
  assign drop       = s1_valid_q && fifo_full;
  assign head       = mem_q[rd_ptr_q[PW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PW-1:0]] <= s1_entry_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
      if (drop)         ovf_q <= 1'b1;
      else if (iClrOvf) ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_q       <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
      done_bank_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      last_q      <= last_d;
      done_q      <= done_d;
      done_bank_q <= done_bank_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!fifo_empty) state_d = S_REQ;
      S_REQ:   if (iWrAck && fifo_empty) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pop         = 1'b0;
    req_d       = req_q;
    addr_d      = addr_q;
    data_d      = data_q;
    last_d      = last_q;
    done_d      = 1'b0;
    done_bank_d = done_bank_q;
    case (state_q)
      S_IDLE: if (!fifo_empty) pop = 1'b1;
      S_REQ: begin
        if (iWrAck) begin
          done_d = last_q;
          if (last_q) done_bank_d = (32'(addr_q) >= FRAME_U);
          if (!fifo_empty) pop = 1'b1;
          else             req_d = 1'b0;
        end
      end
      default: ;
    endcase
    if (pop) begin
      req_d                    = 1'b1;
      {addr_d, data_d, last_d} = head;
    end
  end

  assign oWrReq     = req_q;
  assign oWrAddr    = addr_q;
  assign oWrData    = data_q;
  assign oFrameDone = done_q;
  assign oDoneBank  = done_bank_q;
  assign oOverflow  = ovf_q;

endmodule

// File: doc/pixel_fb_writer.md
Name: pixel_fb_writer

Overview:
- Sits directly downstream of the camera capture stage. Consumes its pixel stream: a strobe plus a 36-bit word {X[9:0], Y[9:0], RGB565[15:0]}.
- Crops each pixel to the configured frame size and computes its linear frame-buffer address in one of two banks (double buffering).
- Buffers address/data pairs in a small FIFO and drains them to the SDRAM write port over a req/ack handshake.
- Reports completed frames so the display reader can switch banks.

Parameters:
- H_RES, 320, active pixels per line; pixels with X >= H_RES are discarded.
- V_RES, 240, active lines per frame; pixels with Y >= V_RES are discarded.
- ADDR_W, 18, word-address width; must satisfy 2*H_RES*V_RES <= 2^ADDR_W.
- FIFO_DEPTH, 16, FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- iEn  in  1  one-cycle pixel-valid strobe from the capture stage.
- iData  in  36  [35:26] X, [25:16] Y, [15:0] RGB565; sampled only when iEn=1.
- iWrAck  in  1  memory accepted the current word; one-cycle pulse, only while oWrReq=1.
- oWrReq  out  1  write request; held until acknowledged.
- oWrAddr  out  ADDR_W  word address; stable while oWrReq=1.
- oWrData  out  16  pixel data; stable while oWrReq=1.
- oFrameDone  out  1  one-cycle pulse when the last pixel of a frame is acknowledged.
- oDoneBank  out  1  bank of the most recently completed frame.
- iClrOvf  in  1  clears oOverflow.
- oOverflow  out  1  sticky; set when an in-range pixel is dropped because the FIFO is full.

Behaviour:
- Reset values: oWrReq=0, oWrAddr=0, oWrData=0, oFrameDone=0, oDoneBank=0, oOverflow=0. Internal state also clears: FIFO empty, cur_bank=0, seen_frame=0, FSM=IDLE.
- Reset asserted mid-request drops oWrReq immediately and discards all buffered data.
- Input acceptance: a pixel is in range when iEn=1, X < H_RES and Y < V_RES. Out-of-range pixels are ignored completely: no FIFO write, no flag, no bank change.
- Bank select, applied when an in-range pixel at (0,0) is accepted:
  - if seen_frame=1, cur_bank toggles; seen_frame is set to 1.
  - The (0,0) pixel itself uses the post-toggle bank, so the first frame after reset goes to bank 0.
- Address: bank*H_RES*V_RES + Y*H_RES + X, computed at full width then truncated to ADDR_W. Multiplies are by constants.
- Stage 1 (address) registers {addr, data, last} one cycle after acceptance. last=1 when X=H_RES-1 and Y=V_RES-1.
- Stage 2 pushes the stage-1 entry into the FIFO. Entry width is ADDR_W+17.
- FIFO full at push time: the entry is dropped and oOverflow is set on the next edge.
  - Set has priority over iClrOvf in the same cycle.
  - A pop in the same cycle does not free space for the push; full is evaluated from registered state.
- Write FSM:
  - IDLE: if the FIFO is non-empty, pop the head into oWrAddr/oWrData/last_reg, set oWrReq=1, go to REQ.
  - REQ: hold all outputs until iWrAck=1. On ack:
    - if the FIFO is non-empty, load the next head in the same edge; oWrReq stays 1 (back-to-back).
    - otherwise oWrReq=0 and go to IDLE.
  - iWrAck while oWrReq=0 is ignored.
- Latency: an in-range pixel sampled at edge 0, with the FIFO empty and the FSM in IDLE, gives oWrReq=1 after edge 3.
- Frame completion: on an acked word with last_reg=1, oFrameDone pulses for one cycle on the next edge and oDoneBank takes that word's bank.
- FIFO pointers wrap modulo FIFO_DEPTH. A full/empty extra pointer bit is used; no entry is lost or duplicated at wrap.
- Simultaneous push and pop on a non-full, non-empty FIFO keeps the occupancy unchanged.

Test Plan:
- Single pixel: iEn with X=5, Y=2, data 16'hF800 (H_RES=320) -> after edge 3 oWrReq=1, oWrAddr=645, oWrData=F800. Ack -> oWrReq=0 next cycle.
- Crop: pixels (320,0) and (0,240) -> no request, oOverflow stays 0. Pixel (319,239) is written to address 76799.
- Back-to-back: 4 consecutive pixels on the same line with iWrAck tied high whenever oWrReq=1 -> 4 acked words, consecutive addresses, oWrReq stays continuously high while the FIFO is non-empty.
- Overflow: 20 pixels with iWrAck held low (FIFO_DEPTH=16) -> oOverflow=1. Then ack everything:
  - exactly 17 words are written (16 buffered entries plus the word held at the output), all in order.
  - iClrOvf clears oOverflow.
- Double buffering (H_RES=4, V_RES=2), two full frames with free-running acks:
  - frame 1 at addresses 0..7, then oFrameDone pulses with oDoneBank=0.
  - frame 2 at addresses 8..15, then oFrameDone pulses with oDoneBank=1.
- Reset mid-operation: assert rst_n low while oWrReq=1 with 5 entries buffered -> all outputs return to reset values. After release, no request appears until a new pixel arrives.
